// File: rtl/alu181_nibble_sequencer_if.sv
// Operation source, result sink and 4-bit ALU slice signals
// for the nibble-serial 181 sequencer.
interface alu181_nibble_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       in_s;
    logic             in_m;
    logic             in_cn;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_f;
    logic             out_cout_n;
    logic             out_aeqb;

    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic             alu_cn;
    logic [3:0]       alu_f;
    logic             alu_cout_n;
    logic             alu_aeqb;

    modport slave (
        input  in_valid, in_a, in_b, in_s, in_m, in_cn,
        input  out_ready,
        input  alu_f, alu_cout_n, alu_aeqb,
        output in_ready,
        output out_valid, out_f, out_cout_n, out_aeqb,
        output alu_a, alu_b, alu_s, alu_m, alu_cn
    );

    modport master (
        output in_valid, in_a, in_b, in_s, in_m, in_cn,
        output out_ready,
        output alu_f, alu_cout_n, alu_aeqb,
        input  in_ready,
        input  out_valid, out_f, out_cout_n, out_aeqb,
        input  alu_a, alu_b, alu_s, alu_m, alu_cn
    );
endinterface

// File: rtl/alu181_nibble_sequencer.sv
// Drives a 4-bit 181-style ALU one nibble per clock, LSB first,
// chaining the active-low carry and ANDing the A=B flag.
module alu181_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input logic                      clk,
    input logic                      rst,
    alu181_nibble_sequencer_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] f_reg;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic             cn_reg;
    logic             eq_reg;
    logic             in_ready_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_f_r;
    logic             cout_r;
    logic             aeqb_r;
    logic [IW+1:0]    base;
    logic [WIDTH-1:0] f_next;

    assign base = {idx, 2'b00};

    always_comb begin
        f_next = f_reg;
        f_next[base +: 4] = bus.alu_f;
    end

    always_comb begin
        bus.alu_a  = 4'd0;
        bus.alu_b  = 4'd0;
        bus.alu_s  = 4'd0;
        bus.alu_m  = 1'b0;
        bus.alu_cn = 1'b1;
        if (state == RUN) begin
            bus.alu_a  = a_reg[base +: 4];
            bus.alu_b  = b_reg[base +: 4];
            bus.alu_s  = s_reg;
            bus.alu_m  = m_reg;
            bus.alu_cn = cn_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            f_reg       <= '0;
            s_reg       <= 4'd0;
            m_reg       <= 1'b0;
            cn_reg      <= 1'b1;
            eq_reg      <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_f_r     <= '0;
            cout_r      <= 1'b1;
            aeqb_r      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_reg      <= bus.in_a;
                        b_reg      <= bus.in_b;
                        s_reg      <= bus.in_s;
                        m_reg      <= bus.in_m;
                        cn_reg     <= bus.in_cn;
                        eq_reg     <= 1'b1;
                        f_reg      <= '0;
                        idx        <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    f_reg  <= f_next;
                    cn_reg <= bus.alu_cout_n;
                    eq_reg <= eq_reg & bus.alu_aeqb;
                    idx    <= idx + 1'b1;
                    // Last nibble: publish straight from the ALU outputs
                    if (idx == LAST) begin
                        idx         <= '0;
                        out_f_r     <= f_next;
                        cout_r      <= bus.alu_cout_n;
                        aeqb_r      <= eq_reg & bus.alu_aeqb;
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_f      = out_f_r;
    assign bus.out_cout_n = cout_r;
    assign bus.out_aeqb   = aeqb_r;
endmodule

// File: tb/tb_alu181_nibble_sequencer.sv
// Bench for alu181_nibble_sequencer: behavioural 181 slice on the
// ALU port, word-level reference model, directed plus random ops.
module tb_alu181_nibble_sequencer;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [3:0] cn_seq;

    alu181_nibble_sequencer_if #(.WIDTH(WIDTH)) bus ();

    alu181_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Function table: 0 add, 1 sub, 2 pass A, 3 xor, 4 and, 5 or, 6 not A
    logic [3:0] fs [7] = '{4'b1001, 4'b0110, 4'b0000, 4'b0110,
                           4'b1011, 4'b1110, 4'b0000};
    logic       fm [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    logic [4:0] nt;
    logic       ncin;
    always_comb begin
        ncin = ~bus.alu_cn;
        nt   = 5'd0;
        case ({bus.alu_m, bus.alu_s})
            5'b0_1001: nt = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'd0, ncin};
            5'b0_0110: nt = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {4'd0, ncin};
            5'b0_0000: nt = {1'b0, bus.alu_a} + {4'd0, ncin};
            5'b1_0110: nt = {1'b0, bus.alu_a ^ bus.alu_b};
            5'b1_1011: nt = {1'b0, bus.alu_a & bus.alu_b};
            5'b1_1110: nt = {1'b0, bus.alu_a | bus.alu_b};
            5'b1_0000: nt = {1'b0, ~bus.alu_a};
            default:   nt = 5'd0;
        endcase
        bus.alu_f      = nt[3:0];
        bus.alu_cout_n = ~nt[4];
        bus.alu_aeqb   = (nt[3:0] == 4'hF);
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {cout_n, aeqb, f}
    function automatic logic [17:0] ref_op(input int fn,
        input logic [15:0] a, input logic [15:0] b, input logic cn);
        logic [16:0] t;
        logic        co;
        logic [16:0] cin;
        cin = cn ? 17'd0 : 17'd1;
        co  = 1'b1;
        case (fn)
            0: t = {1'b0, a} + {1'b0, b} + cin;
            1: t = {1'b0, a} + {1'b0, ~b} + cin;
            2: t = {1'b0, a} + cin;
            3: t = {1'b0, a ^ b};
            4: t = {1'b0, a & b};
            5: t = {1'b0, a | b};
            6: t = {1'b0, ~a};
            default: t = 17'd0;
        endcase
        if (fn < 3) co = ~t[16];
        return {co, t[15:0] == 16'hFFFF, t[15:0]};
    endfunction

    task automatic do_op(input int fn, input logic [15:0] a,
                         input logic [15:0] b, input logic cn,
                         input int hold);
        logic [17:0] e;
        int n;
        e = ref_op(fn, a, b, cn);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("idle_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_s      = fs[fn];
        bus.in_m      = fm[fn];
        bus.in_cn     = cn;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.in_s     = 4'($urandom);
        bus.in_m     = 1'($urandom);
        bus.in_cn    = 1'($urandom);
        for (int k = 0; k < NIB; k++) begin
            @(negedge clk);
            check("run_busy", 32'({bus.out_valid, bus.in_ready}), 32'd0);
            check("run_alu_a", 32'(bus.alu_a), 32'(a[4*k +: 4]));
            check("run_alu_b", 32'(bus.alu_b), 32'(b[4*k +: 4]));
            check("run_alu_sm", 32'({bus.alu_m, bus.alu_s}),
                  32'({fm[fn], fs[fn]}));
            cn_seq[k] = bus.alu_cn;
        end
        @(negedge clk);
        check("latency_valid", 32'(bus.out_valid), 32'd1);
        check("out_f", 32'(bus.out_f), 32'(e[15:0]));
        check("out_cout_n", 32'(bus.out_cout_n), 32'(e[17]));
        check("out_aeqb", 32'(bus.out_aeqb), 32'(e[16]));
        check("done_alu_idle", 32'({bus.alu_a, bus.alu_b, bus.alu_s,
              bus.alu_m, bus.alu_cn}), 32'd1);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                bus.in_valid = 1'b1;
                bus.in_a     = 16'($urandom);
                @(negedge clk);
                check("hold_state", 32'({bus.out_valid, bus.in_ready}),
                      32'd2);
                check("hold_out", 32'({bus.out_cout_n, bus.out_aeqb,
                      bus.out_f}), 32'(e));
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(negedge clk);
        check("back_idle", 32'({bus.out_valid, bus.in_ready}), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ba [3];
        logic [15:0] bb [3];
        logic [15:0] exp_q [$];
        int acc, res, cyc, last;

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_s      = '0;
        bus.in_m      = 1'b0;
        bus.in_cn     = 1'b1;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hs", 32'({bus.in_ready, bus.out_valid}), 32'd2);
        check("rst_out", 32'({bus.out_cout_n, bus.out_aeqb, bus.out_f}),
              32'h20000);
        check("rst_alu", 32'({bus.alu_a, bus.alu_b, bus.alu_s,
              bus.alu_m, bus.alu_cn}), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        do_op(0, 16'h1234, 16'h0FFF, 1'b1, 0);
        check("add_f", 32'(bus.out_f), 32'h2233);
        do_op(0, 16'hFFFF, 16'h0001, 1'b1, 0);
        check("carry_seq", 32'(cn_seq), 32'b0001);
        check("carry_out", 32'(bus.out_cout_n), 32'd0);
        do_op(1, 16'h5000, 16'h0001, 1'b0, 0);
        do_op(1, 16'h3C3C, 16'h3C3C, 1'b1, 0);
        do_op(1, 16'h3C3D, 16'h3C3C, 1'b1, 0);
        do_op(3, 16'hA5A5, 16'hFFFF, 1'b1, 10);
        do_op(0, 16'h0003, 16'h0004, 1'b1, 0);

        // Reset during the second RUN cycle
        bus.in_valid = 1'b1;
        bus.in_a     = 16'h1111;
        bus.in_b     = 16'h2222;
        bus.in_s     = fs[0];
        bus.in_m     = fm[0];
        bus.in_cn    = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_hs", 32'({bus.in_ready, bus.out_valid}), 32'd2);
        check("mid_rst_cn", 32'(bus.alu_cn), 32'd1);
        check("mid_rst_f", 32'(bus.out_f), 32'd0);
        do_op(0, 16'h0001, 16'h0001, 1'b1, 0);

        for (int i = 0; i < 24; i++) begin
            int h;
            h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            do_op(int'($urandom_range(0, 6)), 16'($urandom), 16'($urandom),
                  1'($urandom), h);
        end

        // Back-to-back with in_valid held high
        for (int i = 0; i < 3; i++) begin
            ba[i] = 16'($urandom);
            bb[i] = 16'($urandom);
        end
        bus.out_ready = 1'b1;
        acc = 0;
        res = 0;
        cyc = 0;
        last = 0;
        while (res < 3 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (bus.out_valid) begin
                if (exp_q.size() == 0) check("b2b_extra", 32'd1, 32'd0);
                else check("b2b_f", 32'(bus.out_f), 32'(exp_q.pop_front()));
                res++;
            end
            if (bus.in_ready) begin
                if (acc > 0) check("b2b_gap", 32'(cyc - last), 32'd6);
                last = cyc;
                if (acc < 3) begin
                    bus.in_valid = 1'b1;
                    bus.in_a     = ba[acc];
                    bus.in_b     = bb[acc];
                    bus.in_s     = fs[0];
                    bus.in_m     = fm[0];
                    bus.in_cn    = 1'b1;
                    exp_q.push_back(ba[acc] + bb[acc]);
                end else begin
                    bus.in_valid = 1'b0;
                end
                acc++;
            end
        end
        bus.in_valid = 1'b0;
        check("b2b_done", 32'(res), 32'd3);
        check("b2b_accepts", 32'(acc), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
